// File: rtl/regfile_write_queue_pkg.sv
// +------------------------------------------------------------------+
// | regfile_write_queue_pkg : shared processor widths and defaults   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package regfile_write_queue_pkg;
  localparam int CPU_XLEN  = 64;
  localparam int REG_AW    = 5;
  localparam int WBQ_DEPTH = 4;
endpackage

`default_nettype wire

// File: rtl/regfile_write_queue_fwd_match.sv
// +------------------------------------------------------------------+
// | wbq_fwd_match : youngest-match lookup over age-ordered entries   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module wbq_fwd_match
  import regfile_write_queue_pkg::*;
#(
  parameter int XLEN    = CPU_XLEN,
  parameter int ENTRIES = WBQ_DEPTH + 1
) (
  input  logic [REG_AW-1:0]              i_rs,
  input  logic [ENTRIES-1:0]             i_valid,
  input  logic [ENTRIES-1:0][REG_AW-1:0] i_rd,
  input  logic [ENTRIES-1:0][XLEN-1:0]   i_data,
  output logic                           o_hit,
  output logic [XLEN-1:0]                o_data
);

  // Entry 0 is the oldest; later matches override earlier ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    if (i_rs != '0) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (i_valid[i] && (i_rd[i] == i_rs)) begin
          o_hit  = 1'b1;
          o_data = i_data[i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_queue.sv
// +------------------------------------------------------------------+
// | regfile_write_queue : retire-to-regfile write FIFO w/ forwarding |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter int XLEN  = CPU_XLEN,
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  drain_hold,
  output logic                  RegWrite,
  output logic [REG_AW-1:0]     RD,
  output logic [XLEN-1:0]       WriteData,
  input  logic [REG_AW-1:0]     RS1,
  input  logic [REG_AW-1:0]     RS2,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [XLEN-1:0]       fwd1_data,
  output logic [XLEN-1:0]       fwd2_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int             c_pw    = $clog2(DEPTH);
  localparam int             c_cw    = c_pw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  logic [REG_AW-1:0] r_rd_q   [DEPTH];
  logic [XLEN-1:0]   r_data_q [DEPTH];
  logic [c_pw-1:0]   r_wptr;
  logic [c_pw-1:0]   r_rptr;
  logic [c_cw-1:0]   r_count;

  logic w_accept;
  logic w_push;
  logic w_pop;

  assign wb_ready = (r_count < c_depth);
  assign w_accept = wb_valid && wb_ready;
  assign w_push   = w_accept && (wb_rd != '0);
  // Pop decision uses pre-edge occupancy, so a write into an empty queue waits one edge.
  assign w_pop    = (r_count != '0) && !drain_hold;
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= w_pop;
      if (w_pop) begin
        RD        <= r_rd_q[r_rptr];
        WriteData <= r_data_q[r_rptr];
        r_rptr    <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity lives entirely in count and pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_q[r_wptr]   <= wb_rd;
      r_data_q[r_wptr] <= wb_data;
    end
  end

  logic [DEPTH:0]             w_age_valid;
  logic [DEPTH:0][REG_AW-1:0] w_age_rd;
  logic [DEPTH:0][XLEN-1:0]   w_age_data;

  assign w_age_valid[0] = RegWrite;
  assign w_age_rd[0]    = RD;
  assign w_age_data[0]  = WriteData;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_age
      logic [c_pw-1:0] w_idx;
      assign w_idx            = r_rptr + c_pw'(i);
      assign w_age_valid[i+1] = (c_cw'(i) < r_count);
      assign w_age_rd[i+1]    = r_rd_q[w_idx];
      assign w_age_data[i+1]  = r_data_q[w_idx];
    end
  endgenerate

  wbq_fwd_match #(.XLEN(XLEN), .ENTRIES(DEPTH + 1)) u_fwd1 (
    .i_rs    (RS1),
    .i_valid (w_age_valid),
    .i_rd    (w_age_rd),
    .i_data  (w_age_data),
    .o_hit   (fwd1_hit),
    .o_data  (fwd1_data)
  );

  wbq_fwd_match #(.XLEN(XLEN), .ENTRIES(DEPTH + 1)) u_fwd2 (
    .i_rs    (RS2),
    .i_valid (w_age_valid),
    .i_rd    (w_age_rd),
    .i_data  (w_age_data),
    .o_hit   (fwd2_hit),
    .o_data  (fwd2_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
// +------------------------------------------------------------------+
// | tb_regfile_write_queue : directed bench with issue scoreboard    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_regfile_write_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            drain_hold;
  logic            RegWrite;
  logic [4:0]      RD;
  logic [XLEN-1:0] WriteData;
  logic [4:0]      RS1, RS2;
  logic            fwd1_hit, fwd2_hit;
  logic [XLEN-1:0] fwd1_data, fwd2_data;
  logic [2:0]      count;

  int  errors = 0;
  int  checks = 0;
  wr_t sb[$];

  regfile_write_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .drain_hold (drain_hold),
    .RegWrite   (RegWrite),
    .RD         (RD),
    .WriteData  (WriteData),
    .RS1        (RS1),
    .RS2        (RS2),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one write for one edge; expected acceptance is decided by the caller.
  task automatic offer(input logic [4:0] rd, input logic [XLEN-1:0] data, input logic exp_acc);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    chk("offer_ready", wb_ready, exp_acc);
    if (exp_acc && rd != 5'd0) sb.push_back('{rd: rd, data: data});
    tick();
    wb_valid = 1'b0;
  endtask

  // Every issued write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL issue_unexpected: observed rd=%0d data=%0h expected=none", RD, WriteData);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("issue_rd", RD, e.rd);
        chk("issue_data", WriteData, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    drain_hold = 1'b0; RS1 = '0; RS2 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_rd", RD, 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_ready", wb_ready, 1);

    // Minimum latency: accept at edge N, RegWrite after edge N+1.
    offer(5'd5, 64'hAB, 1'b1);
    chk("lat_count1", count, 1);
    chk("lat_rw_n", RegWrite, 0);
    tick();
    chk("lat_rw_n1", RegWrite, 1);
    chk("lat_rd", RD, 5);
    chk("lat_wdata", WriteData, 64'hAB);
    chk("lat_count0", count, 0);
    tick();
    chk("lat_rw_off", RegWrite, 0);
    chk("lat_rd_hold", RD, 5);

    // Fill under hold, fifth offer refused, then drain in order.
    drain_hold = 1'b1;
    for (int k = 1; k <= 4; k++) offer(5'(k), 64'h100 + 64'(k), 1'b1);
    offer(5'd5, 64'h105, 1'b0);
    chk("hold_count", count, 4);
    chk("hold_rw", RegWrite, 0);
    drain_hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("drain_rw", RegWrite, 1);
      chk("drain_rd", RD, k);
    end
    tick();
    chk("drain_rw_off", RegWrite, 0);
    chk("drain_count", count, 0);

    // Youngest match wins; output stage is the oldest candidate.
    drain_hold = 1'b1;
    offer(5'd7, 64'h11, 1'b1);
    offer(5'd7, 64'h22, 1'b1);
    RS1 = 5'd7; RS2 = 5'd3;
    #1;
    chk("fwd1_hit", fwd1_hit, 1);
    chk("fwd1_data", fwd1_data, 64'h22);
    chk("fwd2_miss_hit", fwd2_hit, 0);
    chk("fwd2_miss_data", fwd2_data, 0);
    drain_hold = 1'b0;
    tick();
    chk("fwd1_mix_data", fwd1_data, 64'h22);
    tick();
    chk("fwd1_out_hit", fwd1_hit, 1);
    chk("fwd1_out_data", fwd1_data, 64'h22);
    tick();
    chk("fwd1_gone_hit", fwd1_hit, 0);
    chk("fwd1_gone_data", fwd1_data, 0);

    // rd=0 is handshaken and dropped; RS=0 never hits.
    RS1 = '0; RS2 = '0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
    #1;
    chk("x0_ready", wb_ready, 1);
    chk("x0_fwd2", fwd2_hit, 0);
    tick();
    wb_valid = 1'b0;
    chk("x0_count", count, 0);
    tick();
    chk("x0_rw", RegWrite, 0);

    // The write on offer this cycle is not forwarded; once queued it is.
    RS2 = 5'd9;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
    #1;
    chk("nofwd_offer", fwd2_hit, 0);
    sb.push_back('{rd: 5'd9, data: 64'h99});
    tick();
    wb_valid = 1'b0;
    chk("fwd2_queued_hit", fwd2_hit, 1);
    chk("fwd2_queued_data", fwd2_data, 64'h99);
    tick();
    tick();
    chk("fwd2_after_hit", fwd2_hit, 0);
    RS2 = '0;

    // Reset mid-operation discards entries and beats a same-edge accept/pop.
    drain_hold = 1'b1;
    offer(5'd10, 64'hA0, 1'b1);
    offer(5'd11, 64'hA1, 1'b1);
    offer(5'd12, 64'hA2, 1'b1);
    chk("pre_rst_count", count, 3);
    reset = 1'b1; drain_hold = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd13; wb_data = 64'hA3;
    tick();
    reset = 1'b0; wb_valid = 1'b0;
    sb.delete();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rw", RegWrite, 0);
    chk("mid_rst_rd", RD, 0);
    chk("mid_rst_ready", wb_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_rw", RegWrite, 0);
    end

    // Full queue, streaming offers: one accept and one issue per cycle through pointer wrap.
    drain_hold = 1'b1;
    for (int k = 0; k < 4; k++) offer(5'(16 + k), 64'hB0 + 64'(k), 1'b1);
    chk("stream_full", count, 4);
    drain_hold = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 64'hC000;
    chk("stream_full_ready", wb_ready, 0);
    tick();
    chk("stream_count_first", count, 3);
    for (int k = 0; k < 10; k++) begin
      chk("stream_ready", wb_ready, 1);
      sb.push_back('{rd: wb_rd, data: wb_data});
      tick();
      chk("stream_rw", RegWrite, 1);
      chk("stream_count", count, 3);
      wb_rd   = 5'(21 + k);
      wb_data = 64'hC001 + 64'(k);
    end
    wb_valid = 1'b0;
    for (int k = 0; k < 20 && count != 0; k++) tick();
    tick();
    chk("end_count", count, 0);
    chk("end_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
